// File: rtl/useq_pkg.sv
// Shared encodings for the microprogram sequencer: FSM states, microinstruction
// field codes, bus/ALU selects and control-word bit positions.
package useq_pkg;

    localparam int             AW_DEF         = 7;
    localparam int             UW_DEF         = 20;
    localparam logic [6:0]     START_ADDR_DEF = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Control word bit positions: {write_enable, clear, increment}
    localparam int CW_WE  = 2;
    localparam int CW_CLR = 1;
    localparam int CW_INC = 0;

    localparam logic [2:0] F1_NOP   = 3'b000;
    localparam logic [2:0] F1_ADD   = 3'b001;
    localparam logic [2:0] F1_CLRAC = 3'b010;
    localparam logic [2:0] F1_INCAC = 3'b011;
    localparam logic [2:0] F1_DRTAC = 3'b100;
    localparam logic [2:0] F1_DRTAR = 3'b101;
    localparam logic [2:0] F1_PCTAR = 3'b110;
    localparam logic [2:0] F1_WRITE = 3'b111;

    localparam logic [2:0] F2_NOP   = 3'b000;
    localparam logic [2:0] F2_SUB   = 3'b001;
    localparam logic [2:0] F2_OR    = 3'b010;
    localparam logic [2:0] F2_AND   = 3'b011;
    localparam logic [2:0] F2_READ  = 3'b100;
    localparam logic [2:0] F2_ACTDR = 3'b101;
    localparam logic [2:0] F2_INCDR = 3'b110;
    localparam logic [2:0] F2_PCTDR = 3'b111;

    localparam logic [2:0] F3_NOP   = 3'b000;
    localparam logic [2:0] F3_XOR   = 3'b001;
    localparam logic [2:0] F3_COM   = 3'b010;
    localparam logic [2:0] F3_SHL   = 3'b011;
    localparam logic [2:0] F3_SHR   = 3'b100;
    localparam logic [2:0] F3_INCPC = 3'b101;
    localparam logic [2:0] F3_ARTPC = 3'b110;
    localparam logic [2:0] F3_HLT   = 3'b111;

    localparam logic [1:0] CD_ONE  = 2'b00;
    localparam logic [1:0] CD_IBIT = 2'b01;
    localparam logic [1:0] CD_SIGN = 2'b10;
    localparam logic [1:0] CD_ZERO = 2'b11;

    localparam logic [1:0] BR_JMP  = 2'b00;
    localparam logic [1:0] BR_CALL = 2'b01;
    localparam logic [1:0] BR_RET  = 2'b10;
    localparam logic [1:0] BR_MAP  = 2'b11;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_COM  = 3'd5;
    localparam logic [2:0] ALU_SHL  = 3'd6;
    localparam logic [2:0] ALU_SHR  = 3'd7;

endpackage

// File: rtl/useq_decode.sv
// Combinational F1/F2/F3 decoder into register control words, bus select, ALU op
// and memory strobes; zero latency, all outputs forced to 0 outside EXEC, no backpressure.
module useq_decode
    import useq_pkg::*;
(
    input  logic       exec_i,
    input  logic [2:0] f1_i,
    input  logic [2:0] f2_i,
    input  logic [2:0] f3_i,
    output logic [2:0] ar_ctrl_o,
    output logic [2:0] pc_ctrl_o,
    output logic [2:0] dr_ctrl_o,
    output logic [2:0] ac_ctrl_o,
    output logic [2:0] bus_sel_o,
    output logic [2:0] alu_op_o,
    output logic       mem_read_o,
    output logic       mem_write_o
);

    // Fields are decoded F3, F2, F1 so the later (higher-priority) field
    // overwrites bus_sel/alu_op, while register control bits accumulate.
    always_comb begin
        ar_ctrl_o   = 3'b000;
        pc_ctrl_o   = 3'b000;
        dr_ctrl_o   = 3'b000;
        ac_ctrl_o   = 3'b000;
        bus_sel_o   = BUS_NONE;
        alu_op_o    = ALU_PASS;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;

        case (f3_i)
            F3_XOR:   begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_XOR; end
            F3_COM:   begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_COM; end
            F3_SHL:   begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_SHL; end
            F3_SHR:   begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_SHR; end
            F3_INCPC: pc_ctrl_o[CW_INC] = 1'b1;
            F3_ARTPC: begin pc_ctrl_o[CW_WE] = 1'b1; bus_sel_o = BUS_AR; end
            default:  ;
        endcase

        case (f2_i)
            F2_SUB:   begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_ADD; end
            F2_OR:    begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_OR; end
            F2_AND:   begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_AND; end
            F2_READ:  begin dr_ctrl_o[CW_WE] = 1'b1; bus_sel_o = BUS_MEM; mem_read_o = 1'b1; end
            F2_ACTDR: begin dr_ctrl_o[CW_WE] = 1'b1; bus_sel_o = BUS_AC; end
            F2_INCDR: dr_ctrl_o[CW_INC] = 1'b1;
            F2_PCTDR: begin dr_ctrl_o[CW_WE] = 1'b1; bus_sel_o = BUS_PC; end
            default:  ;
        endcase

        case (f1_i)
            F1_ADD:   begin ac_ctrl_o[CW_WE] = 1'b1; alu_op_o = ALU_ADD; end
            F1_CLRAC: ac_ctrl_o[CW_CLR] = 1'b1;
            F1_INCAC: ac_ctrl_o[CW_INC] = 1'b1;
            F1_DRTAC: begin ac_ctrl_o[CW_WE] = 1'b1; bus_sel_o = BUS_DR; alu_op_o = ALU_PASS; end
            F1_DRTAR: begin ar_ctrl_o[CW_WE] = 1'b1; bus_sel_o = BUS_DR; end
            F1_PCTAR: begin ar_ctrl_o[CW_WE] = 1'b1; bus_sel_o = BUS_PC; end
            F1_WRITE: begin bus_sel_o = BUS_AC; mem_write_o = 1'b1; end
            default:  ;
        endcase

        if (!exec_i) begin
            ar_ctrl_o   = 3'b000;
            pc_ctrl_o   = 3'b000;
            dr_ctrl_o   = 3'b000;
            ac_ctrl_o   = 3'b000;
            bus_sel_o   = BUS_NONE;
            alu_op_o    = ALU_PASS;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram control unit: CAR/SBR sequencing over a 1-cycle control ROM, two
// cycles per microstep (FETCH, EXEC); controls asserted only in EXEC, no backpressure.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int             AW         = AW_DEF,
    parameter int             UW         = UW_DEF,
    parameter logic [AW-1:0]  START_ADDR = START_ADDR_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [UW-1:0] uinst,
    output logic [AW-1:0] car_addr,
    input  logic [3:0]    opcode,
    input  logic          i_bit,
    input  logic          ac_sign,
    input  logic          ac_zero,
    output logic [2:0]    ar_ctrl,
    output logic [2:0]    pc_ctrl,
    output logic [2:0]    dr_ctrl,
    output logic [2:0]    ac_ctrl,
    output logic [2:0]    bus_sel,
    output logic [2:0]    alu_op,
    output logic          mem_read,
    output logic          mem_write,
    output logic          halted
);

    state_t        state_q, state_d;
    logic [AW-1:0] car_q, car_d;
    logic [AW-1:0] sbr_q, sbr_d;

    logic [2:0]    f1, f2, f3;
    logic [1:0]    cd, br;
    logic [AW-1:0] ad;
    logic [AW-1:0] car_inc;
    logic          cond;
    logic          exec;

    assign f1 = uinst[UW-1 -: 3];
    assign f2 = uinst[UW-4 -: 3];
    assign f3 = uinst[UW-7 -: 3];
    assign cd = uinst[UW-10 -: 2];
    assign br = uinst[UW-12 -: 2];
    assign ad = uinst[AW-1:0];

    assign car_inc = car_q + AW'(1);
    assign exec    = (state_q == ST_EXEC);

    always_comb begin
        cond = 1'b1;
        case (cd)
            CD_ONE:  cond = 1'b1;
            CD_IBIT: cond = i_bit;
            CD_SIGN: cond = ac_sign;
            CD_ZERO: cond = ac_zero;
            default: cond = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            car_q   <= '0;
            sbr_q   <= '0;
        end else begin
            state_q <= state_d;
            car_q   <= car_d;
            sbr_q   <= sbr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        car_d   = car_q;
        sbr_d   = sbr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    car_d   = START_ADDR;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                // HLT still takes its branch so CAR is left pointing past it.
                state_d = (f3 == F3_HLT) ? ST_HALT : ST_FETCH;
                case (br)
                    BR_JMP:  car_d = cond ? ad : car_inc;
                    BR_CALL: begin
                        car_d = cond ? ad : car_inc;
                        if (cond) sbr_d = car_inc;
                    end
                    BR_RET:  car_d = sbr_q;
                    BR_MAP:  car_d = AW'({opcode, 2'b00});
                    default: car_d = car_inc;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    useq_decode u_decode (
        .exec_i      (exec),
        .f1_i        (f1),
        .f2_i        (f2),
        .f3_i        (f3),
        .ar_ctrl_o   (ar_ctrl),
        .pc_ctrl_o   (pc_ctrl),
        .dr_ctrl_o   (dr_ctrl),
        .ac_ctrl_o   (ac_ctrl),
        .bus_sel_o   (bus_sel),
        .alu_op_o    (alu_op),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write)
    );

    assign car_addr = car_q;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a behavioural control ROM and a
// scoreboard of expected EXEC-cycle outputs checked by an independent monitor.
module tb_micro_sequencer;

    typedef struct packed {
        logic [6:0] car;
        logic [2:0] ar;
        logic [2:0] pc;
        logic [2:0] dr;
        logic [2:0] ac;
        logic [2:0] bus;
        logic [2:0] alu;
        logic       mr;
        logic       mw;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] uinst;
    logic [6:0]  car_addr;
    logic [3:0]  opcode;
    logic        i_bit, ac_sign, ac_zero;
    logic [2:0]  ar_ctrl, pc_ctrl, dr_ctrl, ac_ctrl, bus_sel, alu_op;
    logic        mem_read, mem_write, halted;

    logic [19:0] rom [0:127];
    obs_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    micro_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .uinst     (uinst),
        .car_addr  (car_addr),
        .opcode    (opcode),
        .i_bit     (i_bit),
        .ac_sign   (ac_sign),
        .ac_zero   (ac_zero),
        .ar_ctrl   (ar_ctrl),
        .pc_ctrl   (pc_ctrl),
        .dr_ctrl   (dr_ctrl),
        .ac_ctrl   (ac_ctrl),
        .bus_sel   (bus_sel),
        .alu_op    (alu_op),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) uinst <= rom[car_addr];

    // Condition flags keyed to the address being executed.
    always_comb begin
        i_bit   = (car_addr == 7'd70);
        ac_sign = (car_addr == 7'd1);
        ac_zero = (car_addr == 7'd20);
        opcode  = 4'b0101;
    end

    function automatic logic [19:0] mk(input logic [2:0] f1, input logic [2:0] f2,
                                       input logic [2:0] f3, input logic [1:0] cd,
                                       input logic [1:0] br, input logic [6:0] ad);
        return {f1, f2, f3, cd, br, ad};
    endfunction

    function automatic obs_t ob(input logic [6:0] car, input logic [2:0] ar, input logic [2:0] pc,
                                input logic [2:0] dr, input logic [2:0] ac, input logic [2:0] bus,
                                input logic [2:0] alu, input logic mr, input logic mw);
        obs_t o;
        o.car = car; o.ar = ar; o.pc = pc; o.dr = dr; o.ac = ac;
        o.bus = bus; o.alu = alu; o.mr = mr; o.mw = mw;
        return o;
    endfunction

    function automatic obs_t cur();
        return ob(car_addr, ar_ctrl, pc_ctrl, dr_ctrl, ac_ctrl, bus_sel, alu_op, mem_read, mem_write);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {22'd0, ar_ctrl, pc_ctrl, dr_ctrl, ac_ctrl}, 32'd0);
        chk({name, "_bus"}, {27'd0, bus_sel, mem_read, mem_write}, 32'd0);
        chk({name, "_alu"}, {29'd0, alu_op}, 32'd0);
    endtask

    // Monitor: every cycle with any control asserted is one EXEC microstep.
    always @(negedge clk) begin
        if (!rst && (|{ar_ctrl, pc_ctrl, dr_ctrl, ac_ctrl, bus_sel, alu_op, mem_read, mem_write})) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_exec: got %h with no step expected", cur());
            end else begin
                obs_t e;
                e = exp_q.pop_front();
                if (cur() !== e) begin
                    n_fail++;
                    $display("FAIL exec_step car=%0d: got %h expected %h", e.car, cur(), e);
                end
            end
        end
    end

    initial begin
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 20'd0;
        repeat (2) @(negedge clk);
        chk("reset_car", {25'd0, car_addr}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk_quiet("reset_ctrl");

        // Phase A: looping ADD, then reset asserted in the middle of EXEC.
        rom[64] = mk(3'b001, 3'b000, 3'b000, 2'b00, 2'b00, 7'd64);
        exp_q.push_back(ob(7'd64, 3'b000, 3'b000, 3'b000, 3'b100, 3'd0, 3'd1, 1'b0, 1'b0));
        @(negedge clk) rst = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ac_ctrl == 3'b100) found = 1'b1;
        end
        chk("phaseA_exec_seen", {31'd0, found}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midexec_rst_car", {25'd0, car_addr}, 32'd0);
        chk_quiet("midexec_rst_ctrl");

        // Phase B program.
        rom[64]  = mk(3'b110, 3'b000, 3'b000, 2'b00, 2'b00, 7'd65);
        rom[65]  = mk(3'b000, 3'b110, 3'b000, 2'b00, 2'b00, 7'd70);
        rom[70]  = mk(3'b010, 3'b000, 3'b000, 2'b01, 2'b01, 7'd100);
        rom[100] = mk(3'b000, 3'b000, 3'b101, 2'b01, 2'b01, 7'd110);
        rom[101] = mk(3'b000, 3'b100, 3'b000, 2'b00, 2'b10, 7'd0);
        rom[71]  = mk(3'b001, 3'b000, 3'b000, 2'b00, 2'b11, 7'd0);
        rom[20]  = mk(3'b101, 3'b101, 3'b001, 2'b11, 2'b00, 7'd127);
        rom[127] = mk(3'b000, 3'b000, 3'b110, 2'b11, 2'b00, 7'd5);
        rom[0]   = mk(3'b011, 3'b011, 3'b010, 2'b10, 2'b00, 7'd50);
        rom[1]   = mk(3'b100, 3'b000, 3'b100, 2'b10, 2'b00, 7'd3);
        rom[3]   = mk(3'b111, 3'b000, 3'b111, 2'b00, 2'b00, 7'd9);

        exp_q.push_back(ob(7'd64,  3'b100, 3'b000, 3'b000, 3'b000, 3'd2, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd65,  3'b000, 3'b000, 3'b001, 3'b000, 3'd0, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd70,  3'b000, 3'b000, 3'b000, 3'b010, 3'd0, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd100, 3'b000, 3'b001, 3'b000, 3'b000, 3'd0, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd101, 3'b000, 3'b000, 3'b100, 3'b000, 3'd7, 3'd0, 1'b1, 1'b0));
        exp_q.push_back(ob(7'd71,  3'b000, 3'b000, 3'b000, 3'b100, 3'd0, 3'd1, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd20,  3'b100, 3'b000, 3'b100, 3'b100, 3'd3, 3'd4, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd127, 3'b000, 3'b100, 3'b000, 3'b000, 3'd1, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd0,   3'b000, 3'b000, 3'b000, 3'b101, 3'd0, 3'd2, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd1,   3'b000, 3'b000, 3'b000, 3'b100, 3'd3, 3'd0, 1'b0, 1'b0));
        exp_q.push_back(ob(7'd3,   3'b000, 3'b000, 3'b000, 3'b000, 3'd4, 3'd0, 1'b0, 1'b1));

        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_car", {25'd0, car_addr}, 32'd64);
        @(negedge clk);
        chk_quiet("fetch_quiet");

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
        chk("halt_reached", {31'd0, found}, 32'd1);
        chk("steps_left", exp_q.size(), 32'd0);
        chk("halt_car", {25'd0, car_addr}, 32'd9);
        chk_quiet("halt_ctrl");

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_car_frozen", {25'd0, car_addr}, 32'd9);
        chk_quiet("halt_start_ignored");

        #2 rst = 1'b1;
        #1;
        chk("final_rst_halted", {31'd0, halted}, 32'd0);
        chk("final_rst_car", {25'd0, car_addr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram control unit and initiator of the register control interface: owns CAR/SBR, sequences control memory, decodes each 20-bit microinstruction into per-register 3-bit control words {write_enable, clear, increment}, bus select, ALU op and memory strobes.
- Sits between control ROM (synchronous, 1-cycle read) and datapath registers AR, PC, DR, AC.

Parameters:
- AW, 7, control-memory address width (CAR/SBR/AD width)
- UW, 20, microinstruction width: F1[19:17] F2[16:14] F3[13:11] CD[10:9] BR[8:7] AD[6:0]
- START_ADDR, 7'd64, CAR value loaded on start (fetch routine)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE, begin at START_ADDR
- uinst  in  UW  control-memory data, valid the cycle after car_addr presented
- car_addr  out  AW  control-memory address (= CAR)
- opcode  in  4  IR[15:12] for MAP
- i_bit, ac_sign, ac_zero  in  1 each  branch condition flags
- ar_ctrl, pc_ctrl, dr_ctrl, ac_ctrl  out  3 each  {write_enable, clear, increment}
- bus_sel  out  3  0 none,1 AR,2 PC,3 DR,4 AC,7 MEM
- alu_op  out  3  0 pass-DR,1 ADD,2 AND,3 OR,4 XOR,5 COM,6 SHL,7 SHR
- mem_read, mem_write  out  1 each
- halted  out  1  HLT executed

Behaviour:
- Reset (async): state IDLE, CAR=0, SBR=0, all control outputs 0, halted=0.
- FSM IDLE -> FETCH on start; FETCH -> EXEC unconditionally (ROM latency); EXEC -> FETCH, or HALT if F3=111; HALT sticky until rst.
- Control outputs non-zero only in EXEC (one cycle per microinstruction, 2 cycles per microstep).
- start while not IDLE: ignored. Entering FETCH from IDLE: CAR=START_ADDR.
- Condition C by CD: 00 one, 01 i_bit, 10 ac_sign, 11 ac_zero; sampled in EXEC.
- Sequencing at end of EXEC, 7-bit modulo arithmetic (CAR+1 wraps 127 -> 0):
  - BR=00 JMP: C ? CAR=AD : CAR=CAR+1
  - BR=01 CALL: C ? (SBR=CAR+1, CAR=AD) : CAR=CAR+1
  - BR=10 RET: CAR=SBR
  - BR=11 MAP: CAR={0,opcode,2'b00}
- F1: 001 ADD (alu_op=1, ac we); 010 CLRAC (ac clear); 011 INCAC (ac inc); 100 DRTAC (bus DR, alu_op=0, ac we); 101 DRTAR (bus DR, ar we); 110 PCTAR (bus PC, ar we); 111 WRITE (bus AC, mem_write).
- F2: 001 SUB (alu_op=1, ac we; subtract via prior COM/INC in microcode); 010 OR; 011 AND (ac we); 100 READ (bus MEM, mem_read, dr we); 101 ACTDR (bus AC, dr we); 110 INCDR (dr inc); 111 PCTDR (bus PC, dr we).
- F3: 001 XOR; 010 COM; 011 SHL; 100 SHR (each ac we + alu_op); 101 INCPC (pc inc); 110 ARTPC (bus AR, pc we); 111 HLT (no datapath effect, halted=1 next cycle).
- Field 000 = NOP. Multiple fields targeting one register: control bits ORed; register priority (inc > clear > write) resolves. Conflicting bus_sel/alu_op: priority F1 > F2 > F3.
- HLT still performs its BR/CAR update; CAR frozen in HALT.
- rst in any state: immediate return to reset values, outputs 0 in same cycle.

Decomposition:
- Package useq_pkg: FSM state enum, F1/F2/F3/CD/BR encodings, bus_sel/alu_op codes, control-word bit indices (WE=2, CLR=1, INC=0), START_ADDR default.
- Sub-module useq_decode (pure combinational F-field to control-word decoder, gated by EXEC); sequencing/FSM in top.

Test Plan:
- rst high mid-EXEC with ac_ctrl=3'b100 -> all ctrl 0 and car_addr=0 immediately; start -> car_addr=64 next cycle, first EXEC 2 cycles later.
- uinst F1=110,BR=00,CD=00,AD=65 at CAR=64 -> ar_ctrl=3'b100, bus_sel=2 for one cycle; car_addr=65.
- CALL CD=01 at CAR=70, AD=100, i_bit=1 -> CAR=100, SBR=71; later RET -> CAR=71; same with i_bit=0 -> CAR=71, SBR unchanged.
- MAP with opcode=4'b0101 -> CAR=20.
- JMP CD=11 ac_zero=0 at CAR=127 -> CAR wraps to 0.
- F3=111 -> halted=1, state HALT, outputs 0, start ignored until rst.
